// File: rtl/fir_pkg.sv
// Shared defaults and FSM state encoding for the coefficient loader and the
// transposed FIR benches.
package fir_pkg;

  localparam int FIR_DIN_WIDTH = 16;
  localparam int FIR_TAPS      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    PEND  = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow and active coefficient registers. Words land in the shadow bank one at
// a time; a swap copies the whole shadow bank into the active bank in one edge.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int DIN_WIDTH = FIR_DIN_WIDTH,
  parameter int TAPS      = FIR_TAPS,
  localparam int IDXW     = $clog2(TAPS)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            i_wr_en,
  input  logic [IDXW-1:0]                 i_wr_idx,
  input  logic [DIN_WIDTH-1:0]            i_wr_data,
  input  logic                            i_swap,
  output logic [TAPS-1:0][DIN_WIDTH-1:0]  o_coeffs
);

  logic [TAPS-1:0][DIN_WIDTH-1:0] r_shadow;
  logic [TAPS-1:0][DIN_WIDTH-1:0] r_active;

  // Per-tap compare keeps out-of-range indices harmless for non-power-of-two TAPS.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shadow <= '0;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (i_wr_en && (i_wr_idx == IDXW'(i))) begin
          r_shadow[i] <= i_wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_active <= '0;
    end else if (i_swap) begin
      r_active <= r_shadow;
    end
  end

  assign o_coeffs = r_active;

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Coefficient set loader: collects a TAPS-word set into a shadow bank, rejects
// wrong-length sets, and swaps the set in on the next sample boundary.
module fir_coeff_ctrl
  import fir_pkg::*;
#(
  parameter int DIN_WIDTH = FIR_DIN_WIDTH,
  parameter int TAPS      = FIR_TAPS
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            sample_tick,
  input  logic                            cw_valid,
  output logic                            cw_ready,
  input  logic [DIN_WIDTH-1:0]            cw_data,
  input  logic                            cw_last,
  output logic [TAPS-1:0][DIN_WIDTH-1:0]  coeffs,
  output logic                            busy,
  output logic                            swap_done,
  output logic                            len_err
);

  localparam int IDXW = $clog2(TAPS);

  fir_state_e      r_state;
  fir_state_e      w_next;
  logic [IDXW-1:0] r_idx;
  logic            r_swap_done;
  logic            r_len_err;
  logic            w_accept;
  logic            w_idx_last;
  logic            w_wr_en;
  logic            w_len_err_set;
  logic            w_swap;

  assign w_accept   = cw_valid && cw_ready;
  assign w_idx_last = (r_idx == IDXW'(TAPS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !cw_last) w_next = LOAD;
      end
      LOAD: begin
        if (w_accept) begin
          if (cw_last)         w_next = w_idx_last ? PEND : IDLE;
          else if (w_idx_last) w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_accept && cw_last) w_next = IDLE;
      end
      PEND: begin
        if (sample_tick) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // A word is kept only when its cw_last flag agrees with the tap position.
  always_comb begin
    cw_ready      = (r_state != PEND);
    busy          = (r_state != IDLE);
    w_wr_en       = 1'b0;
    w_len_err_set = 1'b0;
    w_swap        = 1'b0;
    case (r_state)
      IDLE: begin
        w_wr_en       = w_accept && !cw_last;
        w_len_err_set = w_accept && cw_last;
      end
      LOAD: begin
        w_wr_en       = w_accept && (cw_last == w_idx_last);
        w_len_err_set = w_accept && (cw_last != w_idx_last);
      end
      PEND: begin
        w_swap = sample_tick;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx       <= '0;
      r_swap_done <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_swap_done <= w_swap;
      r_len_err   <= w_len_err_set;
      if (w_next == IDLE) begin
        r_idx <= '0;
      end else if (w_wr_en && !w_idx_last) begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

  assign swap_done = r_swap_done;
  assign len_err   = r_len_err;

  fir_coeff_bank #(
    .DIN_WIDTH (DIN_WIDTH),
    .TAPS      (TAPS)
  ) u_bank (
    .clk       (clk),
    .rstn      (rstn),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_idx),
    .i_wr_data (cw_data),
    .i_swap    (w_swap),
    .o_coeffs  (coeffs)
  );

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: full loads, swap timing, length errors,
// mid-load reset and gapped loads with stray sample ticks.
module tb_fir_coeff_ctrl;

  localparam int W = 16;
  localparam int T = 8;

  logic              clk;
  logic              rstn;
  logic              sample_tick;
  logic              cw_valid;
  logic              cw_ready;
  logic [W-1:0]      cw_data;
  logic              cw_last;
  logic [T-1:0][W-1:0] coeffs;
  logic              busy;
  logic              swap_done;
  logic              len_err;

  int errors = 0;
  int checks = 0;

  logic [T-1:0][W-1:0] expA;
  logic [T-1:0][W-1:0] expB;
  logic [T-1:0][W-1:0] expC;
  logic [T-1:0][W-1:0] expD;

  fir_coeff_ctrl #(.DIN_WIDTH(W), .TAPS(T)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .sample_tick (sample_tick),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready),
    .cw_data     (cw_data),
    .cw_last     (cw_last),
    .coeffs      (coeffs),
    .busy        (busy),
    .swap_done   (swap_done),
    .len_err     (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [T*W-1:0] obs, input logic [T*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idleCycle(input logic tick);
    sample_tick = tick;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic applyStimulus(input logic [W-1:0] d, input logic last, input logic tick);
    cw_valid    = 1'b1;
    cw_data     = d;
    cw_last     = last;
    sample_tick = tick;
    @(posedge clk); #1;
    cw_valid    = 1'b0;
    cw_last     = 1'b0;
    sample_tick = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; sample_tick = 1'b0; cw_valid = 1'b0; cw_data = '0; cw_last = 1'b0;
    for (int i = 0; i < T; i++) begin
      expA[i] = W'(i + 1);
      expB[i] = W'(16'h0010 + i);
      expC[i] = (i % 2 == 0) ? 16'hFFFF : 16'h8000 + W'(i);
      expD[i] = W'(16'h5A00 + i * 3);
    end

    #12;
    checkOutput("rst_coeffs", coeffs, '0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_swap", swap_done, 0);
    checkOutput("rst_lenerr", len_err, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_ready", cw_ready, 1);

    // Full set 1..8, tick three cycles after the last word
    for (int i = 0; i < T; i++) begin
      applyStimulus(W'(i + 1), (i == T - 1), 1'b0);
      if (i == 3) begin
        checkOutput("a_midload_coeffs", coeffs, '0);
        checkOutput("a_midload_busy", busy, 1);
      end
    end
    checkOutput("a_pend_ready", cw_ready, 0);
    checkOutput("a_pend_busy", busy, 1);
    checkOutput("a_pend_coeffs", coeffs, '0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    idleCycle(1'b1);
    checkOutput("a_swap_pulse", swap_done, 1);
    checkOutput("a_coeffs", coeffs, expA);
    checkOutput("a_busy_after", busy, 0);
    idleCycle(1'b0);
    checkOutput("a_swap_once", swap_done, 0);

    // Tick coincident with the LOAD->PEND word must not swap
    for (int i = 0; i < T; i++) applyStimulus(W'(16'h0010 + i), (i == T - 1), (i == T - 1));
    checkOutput("b_noswap_pulse", swap_done, 0);
    checkOutput("b_noswap_coeffs", coeffs, expA);
    checkOutput("b_still_pend", busy, 1);
    idleCycle(1'b1);
    checkOutput("b_swap_pulse", swap_done, 1);
    checkOutput("b_coeffs", coeffs, expB);

    // Short set of 5 words
    for (int i = 0; i < 5; i++) applyStimulus(W'(16'hC000 + i), (i == 4), 1'b0);
    checkOutput("c_lenerr", len_err, 1);
    checkOutput("c_idle", busy, 0);
    idleCycle(1'b1);
    checkOutput("c_lenerr_once", len_err, 0);
    checkOutput("c_tick_noswap", swap_done, 0);
    checkOutput("c_coeffs", coeffs, expB);

    // Single word carrying last while idle
    applyStimulus(16'h1234, 1'b1, 1'b0);
    checkOutput("s_lenerr", len_err, 1);
    checkOutput("s_idle", busy, 0);

    // Long set of 10 words
    for (int i = 0; i < 10; i++) begin
      applyStimulus(W'(16'hA0 + i), (i == 9), 1'b0);
      if (i == 7) begin
        checkOutput("d_lenerr_8th", len_err, 1);
        checkOutput("d_drain_busy", busy, 1);
      end
      if (i == 8) checkOutput("d_lenerr_9th", len_err, 0);
    end
    checkOutput("d_lenerr_10th", len_err, 0);
    checkOutput("d_idle", busy, 0);
    idleCycle(1'b1);
    checkOutput("d_noswap", swap_done, 0);
    checkOutput("d_coeffs", coeffs, expB);

    // Reset after 4 words, then a fresh bit-exact load
    for (int i = 0; i < 4; i++) applyStimulus(W'(16'h7777), 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    checkOutput("e_rst_coeffs", coeffs, '0);
    checkOutput("e_rst_busy", busy, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    idleCycle(1'b1);
    checkOutput("e_noswap", swap_done, 0);
    checkOutput("e_ready", cw_ready, 1);
    for (int i = 0; i < T; i++) applyStimulus(expC[i], (i == T - 1), 1'b0);
    idleCycle(1'b1);
    checkOutput("e_swap", swap_done, 1);
    checkOutput("e_coeffs", coeffs, expC);

    // Gapped load with stray ticks; old set holds until the swap edge
    for (int i = 0; i < T; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) idleCycle(1'($urandom_range(0, 1)));
      applyStimulus(expD[i], (i == T - 1), 1'b0);
      checkOutput("f_hold_coeffs", coeffs, expC);
    end
    idleCycle(1'b0);
    checkOutput("f_pre_swap", coeffs, expC);
    idleCycle(1'b1);
    checkOutput("f_swap", swap_done, 1);
    checkOutput("f_coeffs", coeffs, expD);
    checkOutput("f_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_coeff_ctrl.md
FIR_COEFF_CTRL -- requirements
Module: fir_coeff_ctrl

Interface
REQ-001 The block SHALL have parameter DIN_WIDTH, default 16, width of one coefficient word.
REQ-002 The block SHALL have parameter TAPS, default 8, number of FIR coefficients (TAPS >= 2).
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rstn  input  1  asynchronous, active-low reset.
REQ-005 Port sample_tick  input  1  one-cycle strobe marking the FIR sample boundary (din update).
REQ-006 Port cw_valid  input  1  coefficient word valid.
REQ-007 Port cw_ready  output  1  coefficient word accepted when cw_valid & cw_ready.
REQ-008 Port cw_data  input  DIN_WIDTH  coefficient word; the first word of a set is tap 0.
REQ-009 Port cw_last  input  1  marks the final word of a coefficient set.
REQ-010 Port coeffs  output  TAPS x DIN_WIDTH (packed [TAPS-1:0][DIN_WIDTH-1:0])  active coefficient bank driving the FIR.
REQ-011 Port busy  output  1  high in any state other than IDLE.
REQ-012 Port swap_done  output  1  one-cycle pulse when a new set becomes active.
REQ-013 Port len_err  output  1  one-cycle pulse when a set is rejected for wrong length.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, DRAIN and PEND.
REQ-015 cw_ready SHALL be high in IDLE, LOAD and DRAIN, and low in PEND.
REQ-016 Accepted words SHALL be written to a shadow bank at index idx; idx resets to 0 on every entry to IDLE.
REQ-017 In IDLE, an accepted word SHALL be written to shadow[0] with idx<=1, and the FSM SHALL move to LOAD (cw_last=1 here: len_err pulse, stay IDLE).
REQ-018 In LOAD, an accepted word without cw_last at idx<TAPS-1 SHALL write shadow[idx], idx<=idx+1, and the FSM SHALL stay in LOAD.
REQ-019 In LOAD, an accepted word with cw_last at idx==TAPS-1 SHALL write shadow[TAPS-1], and the FSM SHALL move to PEND.
REQ-020 In LOAD, an accepted word with cw_last at idx<TAPS-1 SHALL pulse len_err and return the FSM to IDLE; the active bank SHALL be unchanged.
REQ-021 In LOAD, an accepted word without cw_last at idx==TAPS-1 SHALL pulse len_err, and the FSM SHALL move to DRAIN.
REQ-022 In DRAIN, accepted words SHALL be discarded; the word carrying cw_last SHALL return the FSM to IDLE without a second len_err.
REQ-023 In PEND, on sample_tick the whole shadow bank SHALL copy to coeffs in one edge, swap_done SHALL pulse the following cycle, and the FSM SHALL go to IDLE.
REQ-024 A sample_tick in the same cycle as the LOAD->PEND transition SHALL NOT trigger the swap; the swap SHALL wait for the next sample_tick.
REQ-025 coeffs SHALL change only at the PEND swap, never mid-load and never partially.
REQ-026 sample_tick outside PEND SHALL have no effect.
REQ-027 Coefficient words SHALL be stored bit-exact, with no arithmetic or saturation.

Reset
REQ-028 rstn low SHALL asynchronously force IDLE, idx=0, shadow=0, coeffs=0, busy=0, swap_done=0, len_err=0; cw_ready SHALL be 1 after release.
REQ-029 Reset during LOAD or PEND SHALL discard the partial or pending set; no swap_done SHALL follow.

Structure
REQ-030 Package fir_pkg SHALL hold the DIN_WIDTH/TAPS defaults and the FSM state enum, shared with transposed_fir benches.
REQ-031 Sub-module fir_coeff_bank SHALL hold the shadow and active registers with write-enable/index and swap inputs; the FSM SHALL stay in fir_coeff_ctrl.

Verification
REQ-032 Reset, then 8 words 0x0001..0x0008 with last on the 8th, sample_tick 3 cycles later -> coeffs[i]=i+1, one swap_done, busy 0 after.
REQ-033 Set loaded, sample_tick asserted in the LOAD->PEND cycle -> no swap; next tick swaps.
REQ-034 5 words with last on the 5th -> len_err one pulse, coeffs unchanged, FSM IDLE.
REQ-035 10 words with last on the 10th -> len_err once on the 8th word, words 9-10 discarded, coeffs unchanged.
REQ-036 rstn pulsed low mid-load after 4 words -> coeffs=0, no swap_done; a fresh full load then succeeds.
REQ-037 Random cw_valid gaps with FIR in loop: dout matches the reference model using the old set before the swap edge and the new set after it.
